// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts register-addressed commands, issues them to an external ALU,
// writes results back to an 8x16 register file and returns a response. Define ALU_MUL_EN to allow opcode 001.
module alu_cmd_sequencer #(
  parameter int ALU_LAT = 0,
  parameter int NREGS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_srca,
  input  logic [2:0]  cmd_srcb,
  input  logic [2:0]  cmd_dst,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_ovf,
  output logic        rsp_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic [1:0]  alu_ovf,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_NOT   = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;
  localparam logic [2:0] LAST_CNT = 3'(ALU_LAT);

  state_e      r_state;
  state_e      w_next;
  logic [15:0] r_regs [NREGS];
  logic [2:0]  r_op;
  logic [2:0]  r_dst;
  logic [2:0]  r_cnt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_rsp_result;
  logic [1:0]  r_rsp_ovf;
  logic        r_rsp_err;
  logic [15:0] r_ops_done;
  logic        w_accept;
  logic        w_illegal;
  logic        w_final;

  always_comb begin
`ifdef ALU_MUL_EN
    w_illegal = (cmd_op == OP_ILL);
`else
    w_illegal = (cmd_op == OP_ILL) || (cmd_op == OP_MUL);
`endif
  end

  // Accept is decoded from state directly so the ready output never feeds back into itself.
  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_final  = (r_state == S_ISSUE) && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_op    = 3'b000;
    alu_a     = '0;
    alu_b     = '0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) w_next = w_illegal ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        alu_op = r_op;
        alu_a  = r_a;
        alu_b  = r_b;
        if (r_cnt == LAST_CNT) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values;
  // that is what makes operand snapshots ignore a same-edge preload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the register file is reset explicitly because reset must clear its contents.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_op         <= '0;
      r_dst        <= '0;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_result <= '0;
      r_rsp_ovf    <= '0;
      r_rsp_err    <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      if (wr_en) r_regs[wr_addr] <= wr_data;
      if (w_accept) begin
        r_op  <= cmd_op;
        r_dst <= cmd_dst;
        r_a   <= r_regs[cmd_srca];
        r_b   <= (cmd_op == OP_NOT) ? '0 : r_regs[cmd_srcb];
        r_cnt <= '0;
        if (w_illegal) begin
          r_rsp_result <= '0;
          r_rsp_ovf    <= '0;
          r_rsp_err    <= 1'b1;
        end
      end
      if (w_final) begin
        // Placed after the preload write so the writeback wins on an address collision.
        r_regs[r_dst] <= alu_result;
        r_rsp_result  <= alu_result;
        r_rsp_ovf     <= alu_ovf;
        r_rsp_err     <= 1'b0;
        r_ops_done    <= r_ops_done + 16'd1;
      end else if (r_state == S_ISSUE) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign rsp_result = r_rsp_result;
  assign rsp_ovf    = r_rsp_ovf;
  assign rsp_err    = r_rsp_err;
  assign ops_done   = r_ops_done;
  assign rd_data    = r_regs[rd_addr];

endmodule
